// File: rtl/rv32_alu_imm.sv
// rv32_alu_imm: RV32I execute-stage immediate decode, ALU and branch compare with registered output copies
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset (clears *_q only)
//   inst                instruction word (opcode, funct3, inst[30] select the op)
//   in_a, in_b          forwarded operands; shift amount is in_b[4:0]
//   result, take_b, imm combinational ALU result, branch condition, sign-extended immediate
//   result_q, take_b_q, imm_q  the combinational outputs registered on clk
module rv32_alu_imm (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] result,
    output logic        take_b,
    output logic [31:0] imm,
    output logic [31:0] result_q,
    output logic        take_b_q,
    output logic [31:0] imm_q
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  shamt;
    logic [31:0] sum, diff;
    logic        is_r, is_alu, lt, ltu;
    assign op     = inst[6:0];
    assign f3     = inst[14:12];
    assign shamt  = in_b[4:0];
    assign sum    = in_a + in_b;
    assign diff   = in_a - in_b;
    assign lt     = $signed(in_a) < $signed(in_b);
    assign ltu    = in_a < in_b;
    assign is_r   = op == OP_R;
    assign is_alu = is_r || op == OP_IMM;
    always_comb begin
        imm = '0;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYS: imm = {{21{inst[31]}}, inst[30:20]};
            OP_STORE:                         imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
            OP_BR:                            imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:                 imm = {inst[31:12], 12'b0};
            OP_JAL:                           imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default:                          imm = '0;
        endcase
    end
    // Non-ALU classes always add; their funct3 field may hold immediate bits.
    always_comb begin
        result = sum;
        if (is_alu) begin
            case (f3)
                3'b000:  result = (is_r && inst[30]) ? diff : sum;
                3'b001:  result = in_a << shamt;
                3'b010:  result = {31'b0, lt};
                3'b011:  result = {31'b0, ltu};
                3'b100:  result = in_a ^ in_b;
                3'b101:  result = inst[30] ? 32'($signed(in_a) >>> shamt) : in_a >> shamt;
                3'b110:  result = in_a | in_b;
                default: result = in_a & in_b;
            endcase
        end
    end
    always_comb begin
        take_b = 1'b0;
        if (op == OP_BR) begin
            case (f3)
                3'b000:  take_b = in_a == in_b;
                3'b001:  take_b = in_a != in_b;
                3'b100:  take_b = lt;
                3'b101:  take_b = !lt;
                3'b110:  take_b = ltu;
                3'b111:  take_b = !ltu;
                default: take_b = 1'b0;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            take_b_q <= 1'b0;
            imm_q    <= '0;
        end else begin
            result_q <= result;
            take_b_q <= take_b;
            imm_q    <= imm;
        end
    end
endmodule

// File: tb/tb_rv32_alu_imm.sv
// tb_rv32_alu_imm: randomized and directed checking of rv32_alu_imm against an arithmetic reference model
module tb_rv32_alu_imm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = '0, in_a = '0, in_b = '0;
    logic [31:0] result, imm, result_q, imm_q;
    logic        take_b, take_b_q;
    int          n_vec = 0, n_bad = 0;

    rv32_alu_imm dut (
        .clk(clk), .reset(reset), .inst(inst), .in_a(in_a), .in_b(in_b),
        .result(result), .take_b(take_b), .imm(imm),
        .result_q(result_q), .take_b_q(take_b_q), .imm_q(imm_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (inst %08h a %08h b %08h)", tag, got, exp, inst, in_a, in_b);
        end
    endtask

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        int s;
        s = int'(i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return 32'(s >>> 20);
            7'h23: return 32'((s >>> 25) * 32) + 32'(i[11:7]);
            7'h63: return 32'((s >>> 31) * 4096) + 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
            7'h6F: return 32'((s >>> 31) * 1048576) + 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048 + 32'(i[30:21]) * 2;
            7'h37, 7'h17: return i & 32'hFFFFF000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_res(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, sh;
        sa = int'(a);
        sb = int'(b);
        sh = int'(b % 32);
        if (i[6:0] != 7'h33 && i[6:0] != 7'h13) return a + b;
        case (i[14:12])
            3'd0: return (i[6:0] == 7'h33 && i[30]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return i[30] ? 32'(sa >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic m_tb(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (i[6:0] != 7'h63) return 1'b0;
        case (i[14:12])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one vector, check combinational outputs, clock it and check the registered copy.
    task automatic step(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input logic r);
        logic [31:0] er, ei;
        logic        et;
        inst = i; in_a = a; in_b = b; reset = r;
        er = m_res(i, a, b); ei = m_imm(i); et = m_tb(i, a, b);
        #1;
        chk("result", result, er);
        chk("imm", imm, ei);
        chk("take_b", {31'b0, take_b}, {31'b0, et});
        @(posedge clk);
        #1;
        chk("result_q", result_q, r ? 32'h0 : er);
        chk("imm_q", imm_q, r ? 32'h0 : ei);
        chk("take_b_q", {31'b0, take_b_q}, r ? 32'h0 : {31'b0, et});
    endtask

    // Spot values from hand-worked examples, independent of the model.
    task automatic direct(input string tag, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [31:0] ei, input logic et);
        inst = i; in_a = a; in_b = b;
        #1;
        chk({tag, ".result"}, result, er);
        chk({tag, ".imm"}, imm, ei);
        chk({tag, ".take_b"}, {31'b0, take_b}, {31'b0, et});
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h5B};

    initial begin
        logic [31:0] i, a, b;
        @(posedge clk);
        #1;
        step(32'h00000033, 32'h7FFFFFFF, 32'h1, 1'b1);
        reset = 1'b0;
        step(32'h00000033, 32'h7FFFFFFF, 32'h1, 1'b0);
        chk("plan.add_q", result_q, 32'h80000000);
        direct("add",   32'h00000033, 32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0,        1'b0);
        direct("sub",   32'h40000033, 32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,        1'b0);
        direct("addin", 32'hFFF00013, 32'h5,        32'hFFFFFFFF, 32'h4,        32'hFFFFFFFF, 1'b0);
        direct("srai",  32'h40105013, 32'h80000000, 32'h401,      32'hC0000000, 32'h401,      1'b0);
        direct("srli",  32'h00105013, 32'h80000000, 32'h401,      32'h40000000, 32'h1,        1'b0);
        direct("blt",   32'h00004063, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1);
        direct("bltu",  32'h00006063, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b0);
        direct("beq",   32'hFE000FE3, 32'h7,        32'h7,        32'hE,        32'hFFFFFFFE, 1'b1);
        direct("jal",   32'h0040106F, 32'h100,      32'h4,        32'h104,      32'h00001004, 1'b0);
        direct("lui",   32'h12345037, 32'h0,        32'h0,        32'h0,        32'h12345000, 1'b0);
        direct("slt",   32'h00002033, 32'hFFFFFFFF, 32'h0,        32'h1,        32'h0,        1'b0);
        direct("sltu",  32'h00003033, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        1'b0);
        direct("sll",   32'h00001033, 32'h1,        32'h21,       32'h2,        32'h0,        1'b0);
        step(32'h0040106F, 32'h100, 32'h4, 1'b1);
        step(32'h00000033, 32'h7FFFFFFF, 32'h1, 1'b0);
        for (int k = 0; k < 400; k++) begin
            i = {$urandom()} & 32'hFFFFFF80 | 32'(ops[$urandom_range(0, 10)]);
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 4))
                0: b = a;
                1: a = 32'h80000000;
                2: b = 32'(b[5:0]);
                3: a = 32'hFFFFFFFF;
                default: ;
            endcase
            step(i, a, b, ($urandom_range(0, 19) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
